// File: rtl/gauss_residual_checker_if.sv
// Load port, run control and result bus of the Gauss residual checker.
interface gauss_residual_checker_if #(
  parameter int WIDTH = 32,
  parameter int N     = 9
);
  logic                       wr_en;
  logic [1:0]                 wr_sel;
  logic [$clog2(N*N)-1:0]     wr_addr;
  logic [WIDTH-1:0]           wr_data;
  logic                       start;
  logic                       busy;
  logic                       done;
  logic                       error_flag;
  logic [$clog2(N)-1:0]       fail_row;
  logic [$clog2(N+1)-1:0]     fail_count;
  logic [WIDTH-1:0]           max_residual;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, done, error_flag, fail_row, fail_count, max_residual
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, done, error_flag, fail_row, fail_count, max_residual
  );
endinterface

// File: rtl/gauss_residual_checker.sv
// Checks r = A*x - b row by row in fixed point; N MAC cycles plus one check cycle per row.
// Reports first failing row, failure count and the saturated largest |r|.
module gauss_residual_checker #(
  parameter int          WIDTH        = 32,
  parameter int          N            = 9,
  parameter int          FRAC         = 16,
  parameter logic [31:0] TOL          = 32'h0000_0100,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input logic clk,
  input logic rst,
  gauss_residual_checker_if.slave bus
);
  localparam int AW   = $clog2(N*N);
  localparam int RW   = $clog2(N);
  localparam int CW   = $clog2(N+1);
  localparam int ACCW = 2*WIDTH + $clog2(N) + 1;
  localparam logic [AW:0]     NN_L   = (AW+1)'(N*N);
  localparam logic [AW:0]     N_L    = (AW+1)'(N);
  localparam logic [AW-1:0]   N_A    = AW'(N);
  localparam logic [RW-1:0]   LAST   = RW'(N-1);
  localparam logic [ACCW-1:0] WMAX   = {{(ACCW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [ACCW-1:0] TOL_X  = ACCW'(TOL);

  typedef enum logic [1:0] {IDLE, MAC, CHECK, FIN} state_t;

  state_t                   state;
  logic signed [WIDTH-1:0]  a_mem [N*N];
  logic signed [WIDTH-1:0]  x_mem [N];
  logic signed [WIDTH-1:0]  b_mem [N];
  logic signed [WIDTH-1:0]  a_q, x_q, b_q;
  logic signed [ACCW-1:0]   acc;
  logic [RW-1:0]            row, col;
  logic                     busy, done, error_flag;
  logic [RW-1:0]            fail_row;
  logic [CW-1:0]            fail_count;
  logic [WIDTH-1:0]         max_residual;

  logic                     wr_ok;
  logic                     fetch;
  logic [RW-1:0]            fr, fc;
  logic [AW-1:0]            a_idx;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACCW-1:0]   shifted, resid;
  logic [ACCW-1:0]          mag;
  logic                     row_fail;
  logic [WIDTH-1:0]         mag_sat;

  assign wr_ok = bus.wr_en && !busy;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (bus.wr_sel)
        2'd0: if ({1'b0, bus.wr_addr} < NN_L) a_mem[bus.wr_addr] <= bus.wr_data;
        2'd1: if ({1'b0, bus.wr_addr} < N_L)  x_mem[bus.wr_addr[RW-1:0]] <= bus.wr_data;
        2'd2: if ({1'b0, bus.wr_addr} < N_L)  b_mem[bus.wr_addr[RW-1:0]] <= bus.wr_data;
        default: ;
      endcase
    end
  end

  // Next operand pair is fetched one cycle ahead of its MAC cycle.
  always_comb begin
    fetch = 1'b0;
    fr    = '0;
    fc    = '0;
    case (state)
      IDLE: fetch = bus.start;
      MAC: begin
        fetch = 1'b1;
        if (col == LAST) begin
          fr = (row == LAST) ? '0 : row + RW'(1);
          fc = '0;
        end else begin
          fr = row;
          fc = col + RW'(1);
        end
      end
      default: ;
    endcase
  end

  assign a_idx = AW'(fr) * N_A + AW'(fc);

  // A write landing on the same edge as the first fetch is forwarded.
  always_ff @(posedge clk) begin
    if (fetch) begin
      a_q <= (wr_ok && bus.wr_sel == 2'd0 && bus.wr_addr == a_idx) ? bus.wr_data : a_mem[a_idx];
      x_q <= (wr_ok && bus.wr_sel == 2'd1 && bus.wr_addr == AW'(fc)) ? bus.wr_data : x_mem[fc];
    end
    if (state == MAC) b_q <= b_mem[row];
  end

  always_comb begin
    prod     = (2*WIDTH)'(a_q) * (2*WIDTH)'(x_q);
    shifted  = acc >>> FRAC;
    resid    = shifted - ACCW'(b_q);
    mag      = resid[ACCW-1] ? -resid : resid;
    row_fail = mag > TOL_X;
    mag_sat  = (mag > WMAX) ? {WIDTH{1'b1}} : mag[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      error_flag   <= 1'b0;
      fail_row     <= '0;
      fail_count   <= '0;
      max_residual <= '0;
      row          <= '0;
      col          <= '0;
      acc          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            done         <= 1'b0;
            error_flag   <= 1'b0;
            fail_row     <= '0;
            fail_count   <= '0;
            max_residual <= '0;
            row          <= '0;
            col          <= '0;
            acc          <= '0;
            busy         <= 1'b1;
            state        <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACCW'(prod);
          if (col == LAST) begin
            col   <= '0;
            state <= CHECK;
          end else begin
            col <= col + RW'(1);
          end
        end
        CHECK: begin
          if (row_fail) begin
            fail_count <= fail_count + CW'(1);
            if (fail_count == '0) fail_row <= row;
          end
          if (mag_sat > max_residual) max_residual <= mag_sat;
          if (row == LAST || (STOP_ON_FAIL && row_fail)) begin
            state <= FIN;
          end else begin
            row   <= row + RW'(1);
            acc   <= '0;
            state <= MAC;
          end
        end
        FIN: begin
          error_flag <= (fail_count != '0);
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.error_flag   = error_flag;
  assign bus.fail_row     = fail_row;
  assign bus.fail_count   = fail_count;
  assign bus.max_residual = max_residual;
endmodule

// File: tb/tb_gauss_residual_checker.sv
// Directed bench: two N=3 instances (check-all and stop-on-fail) and one N=9 instance.
module tb_gauss_residual_checker;
  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start3, start3s, start9;
  int          tests = 0;
  int          fails = 0;

  gauss_residual_checker_if #(.WIDTH(32), .N(3)) if3  ();
  gauss_residual_checker_if #(.WIDTH(32), .N(3)) if3s ();
  gauss_residual_checker_if #(.WIDTH(32), .N(9)) if9  ();

  assign if3.wr_en    = wr_en;
  assign if3.wr_sel   = wr_sel;
  assign if3.wr_addr  = wr_addr[3:0];
  assign if3.wr_data  = wr_data;
  assign if3.start    = start3;
  assign if3s.wr_en   = wr_en;
  assign if3s.wr_sel  = wr_sel;
  assign if3s.wr_addr = wr_addr[3:0];
  assign if3s.wr_data = wr_data;
  assign if3s.start   = start3s;
  assign if9.wr_en    = wr_en;
  assign if9.wr_sel   = wr_sel;
  assign if9.wr_addr  = wr_addr;
  assign if9.wr_data  = wr_data;
  assign if9.start    = start9;

  gauss_residual_checker #(.WIDTH(32), .N(3), .FRAC(16), .TOL(32'h100), .STOP_ON_FAIL(1'b0))
    u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  gauss_residual_checker #(.WIDTH(32), .N(3), .FRAC(16), .TOL(32'h100), .STOP_ON_FAIL(1'b1))
    u_dut3s (.clk(clk), .rst(rst), .bus(if3s.slave));
  gauss_residual_checker #(.WIDTH(32), .N(9), .FRAC(16), .TOL(32'h100), .STOP_ON_FAIL(1'b0))
    u_dut9 (.clk(clk), .rst(rst), .bus(if9.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [6:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_sel = s; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       start3  = v;
      1:       start3s = v;
      default: start9  = v;
    endcase
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return if3.done;
      1:       return if3s.done;
      default: return if9.done;
    endcase
  endfunction

  function automatic logic busy_of(input int which);
    case (which)
      0:       return if3.busy;
      1:       return if3s.busy;
      default: return if9.busy;
    endcase
  endfunction

  // mode 1: write issued together with start; mode 2: write issued while busy
  task automatic run(input int which, input int exp_lat, input string tag, input int mode,
                     input logic [1:0] s, input logic [6:0] a, input logic [31:0] d);
    int n;
    if (mode == 1) begin wr_en = 1'b1; wr_sel = s; wr_addr = a; wr_data = d; end
    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
    wr_en = 1'b0;
    if (mode == 2) begin wr_en = 1'b1; wr_sel = s; wr_addr = a; wr_data = d; end
    check({tag, "_busy"}, 64'(busy_of(which)), 64'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      wr_en = 1'b0;
      n++;
    end while (!done_of(which) && n < 300);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_idle"}, 64'(busy_of(which)), 64'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 2'd0; wr_addr = '0; wr_data = '0;
    start3 = 1'b0; start3s = 1'b0; start9 = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", 64'(if3.busy), 64'd0);
    check("rst_done", 64'(if3.done), 64'd0);
    check("rst_err",  64'(if3.error_flag), 64'd0);
    check("rst_cnt",  64'(if3.fail_count), 64'd0);
    check("rst_max",  64'(if3.max_residual), 64'd0);

    // Identity A; x[0] arrives together with start
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        wr(2'd0, 7'(i*3 + j), (i == j) ? 32'h0001_0000 : 32'h0);
    for (int i = 0; i < 3; i++) wr(2'd2, 7'(i), 32'((i + 1) << 16));
    for (int i = 1; i < 3; i++) wr(2'd1, 7'(i), 32'((i + 1) << 16));
    wr(2'd3, 7'd0, 32'h0);
    wr(2'd1, 7'd3, 32'h0);
    run(0, 13, "s1", 1, 2'd1, 7'd0, 32'h0001_0000);
    check("s1_err", 64'(if3.error_flag), 64'd0);
    check("s1_cnt", 64'(if3.fail_count), 64'd0);
    check("s1_max", 64'(if3.max_residual), 64'd0);
    check("s1_row", 64'(if3.fail_row), 64'd0);

    wr(2'd2, 7'd1, 32'h0002_8000);
    for (int i = 0; i < 3; i++) wr(2'd1, 7'(i), 32'((i + 1) << 16));
    run(0, 13, "s2", 0, 2'd0, 7'd0, 32'h0);
    check("s2_err", 64'(if3.error_flag), 64'd1);
    check("s2_row", 64'(if3.fail_row), 64'd1);
    check("s2_cnt", 64'(if3.fail_count), 64'd1);
    check("s2_max", 64'(if3.max_residual), 64'h8000);

    run(1, 9, "s3", 0, 2'd0, 7'd0, 32'h0);
    check("s3_err", 64'(if3s.error_flag), 64'd1);
    check("s3_row", 64'(if3s.fail_row), 64'd1);
    check("s3_cnt", 64'(if3s.fail_count), 64'd1);
    check("s3_max", 64'(if3s.max_residual), 64'h8000);

    wr(2'd2, 7'd1, 32'h0002_0000);
    wr(2'd2, 7'd0, 32'h0001_0100);
    run(0, 13, "s4a", 0, 2'd0, 7'd0, 32'h0);
    check("s4a_err", 64'(if3.error_flag), 64'd0);
    check("s4a_max", 64'(if3.max_residual), 64'h100);
    run(0, 13, "s4b", 1, 2'd2, 7'd0, 32'h0001_0101);
    check("s4b_err", 64'(if3.error_flag), 64'd1);
    check("s4b_row", 64'(if3.fail_row), 64'd0);
    check("s4b_cnt", 64'(if3.fail_count), 64'd1);
    check("s4b_max", 64'(if3.max_residual), 64'h101);

    // Reset after row 0 has already been counted as failing
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("s5_pre_cnt", 64'(if3.fail_count), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("s5_busy", 64'(if3.busy), 64'd0);
    check("s5_done", 64'(if3.done), 64'd0);
    check("s5_err",  64'(if3.error_flag), 64'd0);
    check("s5_cnt",  64'(if3.fail_count), 64'd0);
    check("s5_max",  64'(if3.max_residual), 64'd0);
    wr(2'd2, 7'd0, 32'h0001_0000);
    run(0, 13, "s5r", 2, 2'd1, 7'd0, 32'h0);
    check("s5r_err", 64'(if3.error_flag), 64'd0);
    check("s5r_cnt", 64'(if3.fail_count), 64'd0);
    check("s5r_max", 64'(if3.max_residual), 64'd0);

    for (int i = 0; i < 81; i++) wr(2'd0, 7'(i), 32'h8000_0000);
    for (int i = 0; i < 9; i++) wr(2'd1, 7'(i), 32'h8000_0000);
    for (int i = 0; i < 9; i++) wr(2'd2, 7'(i), 32'h0);
    run(2, 91, "s6", 0, 2'd0, 7'd0, 32'h0);
    check("s6_err", 64'(if9.error_flag), 64'd1);
    check("s6_cnt", 64'(if9.fail_count), 64'd9);
    check("s6_row", 64'(if9.fail_row), 64'd0);
    check("s6_max", 64'(if9.max_residual), 64'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
